core_seq: RTL
=============

CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 SHALL have parameter NCORE, default 16, meaning the number of cores chained on the output shift path (2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request one dot-product pass; sampled only in IDLE.
REQ-005 SHALL have port len  input  5  dot-product length; 1..31 literal, 0 means 32; latched on accepted start.
REQ-006 SHALL have port d_valid  input  1  activation word on the shared d bus is valid this cycle.
REQ-007 SHALL have port init  output  1  clears every core accumulator.
REQ-008 SHALL have port exec  output  1  issues one weight-read/MAC step to all cores.
REQ-009 SHALL have port ra  output  5  weight row address for the exec step.
REQ-010 SHALL have port update  output  1  selects fma result onto each core output.
REQ-011 SHALL have port outr  output  1  captures/shifts the core output chain.
REQ-012 SHALL have port nrm_en  output  1  enable to the normalize stage; last core output valid.
REQ-013 SHALL have port res_idx  output  5  core index of the result presented while nrm_en=1.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of pass.
REQ-016 SHALL have port d_one  output  1  forces d bus to bf16 1.0 (16'h3F80); present only with CORE_SEQ_BIAS_EN.

Function
REQ-017 SHALL implement states IDLE, INIT, EXEC, BIAS, DRAIN, UPDT, SHIFT, DONE.
REQ-018 SHALL go IDLE->INIT on start=1; start in any other state SHALL be ignored.
REQ-019 SHALL assert init=1 for exactly the one INIT cycle, then enter EXEC with step counter=0.
REQ-020 In EXEC, exec SHALL equal d_valid and ra SHALL equal the step counter; counter increments only on exec=1 (stall holds ra).
REQ-021 After the exec with ra=len-1 (31 when len=0), SHALL go to BIAS if enabled, else DRAIN.
REQ-022 DRAIN SHALL last exactly 3 cycles (core exec-to-accumulate depth) with all strobes low.
REQ-023 UPDT SHALL last one cycle with update=1, outr=1, nrm_en=1, res_idx=NCORE-1.
REQ-024 SHIFT SHALL last NCORE-1 cycles with update=0, outr=1, nrm_en=1, res_idx decrementing NCORE-2..0.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE; start in DONE is ignored.
REQ-026 At most one of init, exec, update SHALL be high in any cycle; all outputs are registered.
REQ-027 ra SHALL be 0 outside EXEC/BIAS; res_idx SHALL be 0 when nrm_en=0.
REQ-028 Pass latency with d_valid tied high SHALL be 1+L+3+NCORE+1 cycles from start to done (L=effective length, +1 with bias).

Reset
REQ-029 rst_n low SHALL force IDLE, counters 0 and every output 0 immediately, including mid-pass; a pass in flight is abandoned, not resumed.
REQ-030 After rst_n release the first accepted start SHALL behave per REQ-018.

Configuration
REQ-031 Macro CORE_SEQ_BIAS_EN defined: BIAS state lasts until one exec with d_valid ignored (exec=1, ra=L, d_one=1, single cycle), then DRAIN; len=0 with bias SHALL saturate to 31 data rows.
REQ-032 CORE_SEQ_BIAS_EN undefined: no BIAS state, no d_one port, EXEC->DRAIN directly.

Structure
REQ-033 SHALL take the state enum, DRAIN_CYCLES=3 and BF16_ONE=16'h3F80 from shared package core_pkg.
REQ-034 SHALL be a single module; the output-shift counter MAY be sub-module shift_cnt (down-counter with load and zero flag).

Verification
REQ-035 NCORE=4, len=3, d_valid=1: init@c1, exec@c2-c4 ra=0,1,2, update@c8, nrm_en@c8-c11 res_idx=3,2,1,0, done@c12.
REQ-036 len=4, d_valid=1,0,0,1,1,1: ra=0 then held 1 during two stalls; exactly 4 exec pulses.
REQ-037 len=0: exactly 32 exec pulses, ra 0..31, no wrap to 0 extra step.
REQ-038 rst_n low at 2nd EXEC cycle: all outputs 0 same cycle; later start runs a full clean pass.
REQ-039 start held high through a pass: second pass starts one cycle after done, never earlier.
REQ-040 CORE_SEQ_BIAS_EN, len=2: exec ra=0,1 then ra=2 with d_one=1 while d_valid=0; done one cycle later than REQ-035 timing.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core-array pass sequencer.
package core_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_EXEC,
      S_BIAS,
      S_DRAIN,
      S_UPDT,
      S_SHIFT,
      S_DONE
   } state_t;

   // Exec-to-accumulate pipeline depth inside each core.
   localparam int DRAIN_CYCLES = 3;

   // Value the d bus is forced to while d_one is high.
   localparam logic [15:0] BF16_ONE = 16'h3F80;

endpackage

// File: rtl/shift_cnt.sv
// Down-counter with synchronous load, saturating at zero, with a zero flag.
module shift_cnt #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] q,
   output logic         zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (dec && (q != '0)) begin
         q <= q - W'(1);
      end
   end

   assign zero = (q == '0);

endmodule

// File: rtl/core_seq.sv
// Sequencer for one dot-product pass across a chain of NCORE cores.
// Optional bias row (d bus forced to 1.0) enabled by macro CORE_SEQ_BIAS_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start
//   INIT    | one cycle, clears all core accumulators
//   EXEC    | one MAC step per valid activation word, rows 0..last
//   BIAS    | one extra MAC step with d forced to 1.0 (bias build only)
//   DRAIN   | wait for the core MAC pipeline to settle
//   UPDT    | load results into the output chain, last core presented
//   SHIFT   | shift the chain, remaining cores presented high-to-low
//   DONE    | one-cycle completion pulse
module core_seq
   import core_pkg::*;
#(
   parameter int NCORE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [4:0] len,
   input  logic       d_valid,
   output logic       init,
   output logic       exec,
   output logic [4:0] ra,
   output logic       update,
   output logic       outr,
   output logic       nrm_en,
   output logic [4:0] res_idx,
   output logic       busy,
   output logic       done
`ifdef CORE_SEQ_BIAS_EN
   ,
   output logic       d_one
`endif
);

   localparam logic [4:0] LAST_IDX   = 5'(NCORE - 1);
   localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES - 1);

   state_t     state;
   logic [4:0] last_row;
   logic [1:0] drain_cnt;
   logic       sc_load;
   logic       sc_dec;
   logic       sc_zero;

   // The output chain counter doubles as res_idx: it is zero whenever idle.
   assign sc_load = (state == S_DRAIN) && (drain_cnt == 2'd0);
   assign sc_dec  = (state == S_UPDT) || (state == S_SHIFT);

   shift_cnt #(
      .W(5)
   ) u_shift_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (sc_load),
      .dec      (sc_dec),
      .load_val (LAST_IDX),
      .q        (res_idx),
      .zero     (sc_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         last_row  <= '0;
         drain_cnt <= '0;
         init      <= 1'b0;
         exec      <= 1'b0;
         ra        <= '0;
         update    <= 1'b0;
         outr      <= 1'b0;
         nrm_en    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef CORE_SEQ_BIAS_EN
         d_one     <= 1'b0;
`endif
      end else begin
         init   <= 1'b0;
         update <= 1'b0;
         done   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_INIT;
                  init  <= 1'b1;
                  busy  <= 1'b1;
`ifdef CORE_SEQ_BIAS_EN
                  // Bias takes the 32nd row, so len=0 leaves 31 data rows.
                  last_row <= (len == 5'd0) ? 5'd30 : len - 5'd1;
`else
                  last_row <= len - 5'd1;
`endif
               end
            end
            S_INIT: begin
               state <= S_EXEC;
               exec  <= d_valid;
               ra    <= '0;
            end
            S_EXEC: begin
               if (exec && (ra == last_row)) begin
`ifdef CORE_SEQ_BIAS_EN
                  state <= S_BIAS;
                  exec  <= 1'b1;
                  ra    <= ra + 5'd1;
                  d_one <= 1'b1;
`else
                  state     <= S_DRAIN;
                  exec      <= 1'b0;
                  ra        <= '0;
                  drain_cnt <= DRAIN_LOAD;
`endif
               end else begin
                  if (exec) begin
                     ra <= ra + 5'd1;
                  end
                  exec <= d_valid;
               end
            end
`ifdef CORE_SEQ_BIAS_EN
            S_BIAS: begin
               state     <= S_DRAIN;
               exec      <= 1'b0;
               ra        <= '0;
               d_one     <= 1'b0;
               drain_cnt <= DRAIN_LOAD;
            end
`endif
            S_DRAIN: begin
               if (drain_cnt == 2'd0) begin
                  state  <= S_UPDT;
                  update <= 1'b1;
                  outr   <= 1'b1;
                  nrm_en <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt - 2'd1;
               end
            end
            S_UPDT: begin
               state <= S_SHIFT;
            end
            S_SHIFT: begin
               if (sc_zero) begin
                  state  <= S_DONE;
                  outr   <= 1'b0;
                  nrm_en <= 1'b0;
                  done   <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               exec  <= 1'b0;
               ra    <= '0;
               outr  <= 1'b0;
               nrm_en <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
